// File: rtl/ps2_pkg.sv
// ps2_pkg: state codes, PS/2 command/response bytes and packet sync bit for the mouse master
package ps2_pkg;
    localparam logic [3:0] S_POWERUP      = 4'd0;
    localparam logic [3:0] S_SEND_FF      = 4'd1;
    localparam logic [3:0] S_WAIT_FF_SENT = 4'd2;
    localparam logic [3:0] S_WAIT_FA      = 4'd3;
    localparam logic [3:0] S_WAIT_AA      = 4'd4;
    localparam logic [3:0] S_WAIT_ID      = 4'd5;
    localparam logic [3:0] S_SEND_F4      = 4'd6;
    localparam logic [3:0] S_WAIT_F4_SENT = 4'd7;
    localparam logic [3:0] S_WAIT_F4_ACK  = 4'd8;
    localparam logic [3:0] S_PKT0         = 4'd9;
    localparam logic [3:0] S_PKT1         = 4'd10;
    localparam logic [3:0] S_PKT2         = 4'd11;
    localparam logic [3:0] S_INTR         = 4'd12;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_SELFTEST = 8'hAA;
    localparam logic [7:0] RSP_ID       = 8'h00;
    localparam int SYNC_BIT = 3;
endpackage

// File: rtl/mouse_master_sm_if.sv
// mouse_master_sm_if: transceiver handshake plus processor-facing packet registers
interface mouse_master_sm_if;
    logic       send_byte;
    logic [7:0] byte_to_send;
    logic       byte_sent;
    logic       read_enable;
    logic [7:0] byte_read;
    logic [1:0] byte_error_code;
    logic       byte_ready;
    logic [7:0] mouse_status;
    logic [7:0] mouse_dx;
    logic [7:0] mouse_dy;
    logic       send_interrupt;
    logic       init_done;
    logic [3:0] master_state;

    modport master (
        output send_byte, byte_to_send, read_enable,
        output mouse_status, mouse_dx, mouse_dy, send_interrupt, init_done, master_state,
        input  byte_sent, byte_read, byte_error_code, byte_ready
    );

    modport slave (
        input  send_byte, byte_to_send, read_enable,
        input  mouse_status, mouse_dx, mouse_dy, send_interrupt, init_done, master_state,
        output byte_sent, byte_read, byte_error_code, byte_ready
    );
endinterface

// File: rtl/mouse_master_sm.sv
// mouse_master_sm: PS/2 mouse init handshake and 3-byte stream packet assembly
module mouse_master_sm
    import ps2_pkg::*;
#(
    parameter logic [31:0] POWERUP_CYCLES = 32'd1000000,
    parameter logic [31:0] RESP_TIMEOUT   = 32'd50000000,
    parameter logic [31:0] PKT_TIMEOUT    = 32'd2000000
) (
    input  logic               clk,
    input  logic               rst_n,
    mouse_master_sm_if.master  bus
);
    logic [3:0]  state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  byte_to_send_q, byte_to_send_d;
    logic [7:0]  shadow0_q, shadow0_d, shadow1_q, shadow1_d, shadow2_q, shadow2_d;
    logic [7:0]  status_q, status_d, dx_q, dx_d, dy_q, dy_d;
    logic        intr_q, intr_d;
    logic        init_done_q, init_done_d;
    logic        accepted, resp_to, pkt_to;
    logic [7:0]  exp_rsp;

    // Next-state, shadow capture and timer; every wait/packet state advances to state+1 on success
    always_comb begin
        accepted = bus.byte_ready && (bus.byte_error_code == 2'b00);
        exp_rsp = (state_q == S_WAIT_AA) ? RSP_SELFTEST : (state_q == S_WAIT_ID) ? RSP_ID : RSP_ACK;
        resp_to = timer_q == RESP_TIMEOUT - 32'd1;
        pkt_to = timer_q == PKT_TIMEOUT - 32'd1;
        state_d = state_q;
        shadow0_d = shadow0_q;
        shadow1_d = shadow1_q;
        shadow2_d = shadow2_q;
        status_d = status_q;
        dx_d = dx_q;
        dy_d = dy_q;
        intr_d = 1'b0;
        case (state_q)
            S_POWERUP: state_d = (timer_q == POWERUP_CYCLES - 32'd1) ? S_SEND_FF : S_POWERUP;
            S_SEND_FF: state_d = S_WAIT_FF_SENT;
            S_SEND_F4: state_d = S_WAIT_F4_SENT;
            S_WAIT_FF_SENT, S_WAIT_F4_SENT:
                state_d = bus.byte_sent ? state_q + 4'd1 : resp_to ? S_SEND_FF : state_q;
            S_WAIT_FA, S_WAIT_AA, S_WAIT_ID, S_WAIT_F4_ACK:
                state_d = bus.byte_ready ? ((accepted && bus.byte_read == exp_rsp) ? state_q + 4'd1 : S_SEND_FF)
                                         : resp_to ? S_SEND_FF : state_q;
            S_PKT0: begin
                shadow0_d = (accepted && bus.byte_read[SYNC_BIT]) ? bus.byte_read : shadow0_q;
                state_d = (accepted && bus.byte_read[SYNC_BIT]) ? S_PKT1 : S_PKT0;
            end
            S_PKT1: begin
                shadow1_d = accepted ? bus.byte_read : shadow1_q;
                state_d = bus.byte_ready ? (accepted ? S_PKT2 : S_PKT0) : pkt_to ? S_PKT0 : S_PKT1;
            end
            S_PKT2: begin
                shadow2_d = accepted ? bus.byte_read : shadow2_q;
                state_d = bus.byte_ready ? (accepted ? S_INTR : S_PKT0) : pkt_to ? S_PKT0 : S_PKT2;
            end
            S_INTR: begin
                status_d = shadow0_q;
                dx_d = shadow1_q;
                dy_d = shadow2_q;
                intr_d = 1'b1;
                state_d = S_PKT0;
            end
            default: state_d = S_POWERUP;
        endcase
        init_done_d = init_done_q | (state_q == S_WAIT_F4_ACK && state_d == S_PKT0);
        byte_to_send_d = (state_d == S_SEND_FF) ? CMD_RESET : (state_d == S_SEND_F4) ? CMD_ENABLE : byte_to_send_q;
        timer_d = (state_d != state_q) ? 32'd0 : timer_q + 32'd1;
    end

    // State, timer and published registers; async reset clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_POWERUP;
            timer_q <= '0;
            byte_to_send_q <= '0;
            shadow0_q <= '0;
            shadow1_q <= '0;
            shadow2_q <= '0;
            status_q <= '0;
            dx_q <= '0;
            dy_q <= '0;
            intr_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            byte_to_send_q <= byte_to_send_d;
            shadow0_q <= shadow0_d;
            shadow1_q <= shadow1_d;
            shadow2_q <= shadow2_d;
            status_q <= status_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            intr_q <= intr_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.send_byte = (state_q == S_SEND_FF) || (state_q == S_SEND_F4);
    assign bus.read_enable = state_q inside {S_WAIT_FA, S_WAIT_AA, S_WAIT_ID, S_WAIT_F4_ACK, S_PKT0, S_PKT1, S_PKT2};
    assign bus.byte_to_send = byte_to_send_q;
    assign bus.mouse_status = status_q;
    assign bus.mouse_dx = dx_q;
    assign bus.mouse_dy = dy_q;
    assign bus.send_interrupt = intr_q;
    assign bus.init_done = init_done_q;
    assign bus.master_state = state_q;
endmodule
